// File: rtl/mc_muldiv.sv
// Iterative multiply/divide unit: UMULL/SMULL by radix-2 shift-add, UDIV/SDIV by restoring division.
// Divide datapath is compiled in only when MC_MULDIV_DIV_EN is defined.
module mc_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t                 state_r, state_s;
  logic                   accept_s, last_s;
  logic [CW-1:0]          cnt_r;
  logic                   div_r;
  logic                   neg_q_r;
  logic [WIDTH-1:0]       opnd_r;
  logic [2*WIDTH-1:0]     acc_r;
  logic [2*WIDTH-1:0]     step_s;
  logic [WIDTH:0]         mul_sum_s;
  logic [2*WIDTH-1:0]     prod_s;
  logic                   sa_s, sb_s;
  logic                   busy_r, done_r, divzero_r;
  logic [WIDTH-1:0]       result_lo_r, result_hi_r;
  logic [3:0]             flags_r;
  logic [WIDTH-1:0]       fin_lo_s, fin_hi_s;
  logic [3:0]             fin_flags_s;
  logic                   fin_dz_s;
`ifdef MC_MULDIV_DIV_EN
  logic                   neg_r_r, dz_r, ovf_r;
  logic [WIDTH-1:0]       a_raw_r;
  logic [WIDTH:0]         div_sh_s, div_sub_s;
  logic [2*WIDTH-1:0]     div_next_s;
  logic [WIDTH-1:0]       q_s, r_s;
  logic                   fin_v_s;
`endif

  assign sa_s = op[0] & a[WIDTH-1];
  assign sb_s = op[0] & b[WIDTH-1];

  // Next-state decode: starts are only honoured in IDLE and DONE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_s = ST_DONE;
          last_s  = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // One iteration of shift-add multiply (and restoring divide when built in).
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
`ifdef MC_MULDIV_DIV_EN
    div_sh_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_sub_s = div_sh_s - {1'b0, opnd_r};
    if (div_sh_s >= {1'b0, opnd_r}) begin
      div_next_s = {div_sub_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
    step_s = div_r ? div_next_s : {mul_sum_s, acc_r[WIDTH-1:1]};
`else
    step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
`endif
  end

  // Sign correction, special cases and flags applied to the final iteration.
  always_comb begin
    prod_s      = neg_q_r ? -step_s : step_s;
    fin_lo_s    = prod_s[WIDTH-1:0];
    fin_hi_s    = prod_s[2*WIDTH-1:WIDTH];
    fin_flags_s = {prod_s[2*WIDTH-1], (prod_s == {(2*WIDTH){1'b0}}), 1'b0, 1'b0};
    fin_dz_s    = 1'b0;
`ifdef MC_MULDIV_DIV_EN
    q_s     = neg_q_r ? -step_s[WIDTH-1:0] : step_s[WIDTH-1:0];
    r_s     = neg_r_r ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
    fin_v_s = 1'b0;
`endif
    if (div_r) begin
`ifdef MC_MULDIV_DIV_EN
      if (dz_r) begin
        fin_lo_s = {WIDTH{1'b1}};
        fin_hi_s = a_raw_r;
        fin_dz_s = 1'b1;
      end else if (ovf_r) begin
        fin_lo_s = a_raw_r;
        fin_hi_s = {WIDTH{1'b0}};
        fin_v_s  = 1'b1;
      end else begin
        fin_lo_s = q_s;
        fin_hi_s = r_s;
      end
      fin_flags_s = {fin_lo_s[WIDTH-1], (fin_lo_s == {WIDTH{1'b0}}), 1'b0, fin_v_s};
`else
      fin_lo_s    = {WIDTH{1'b0}};
      fin_hi_s    = {WIDTH{1'b0}};
      fin_flags_s = 4'b0100;
`endif
    end else begin
      fin_dz_s = 1'b0;
    end
  end

  // Control state, operand latching and iteration datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      div_r   <= 1'b0;
      neg_q_r <= 1'b0;
      opnd_r  <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
`ifdef MC_MULDIV_DIV_EN
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
      a_raw_r <= {WIDTH{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
      if (accept_s) begin
        cnt_r   <= {CW{1'b0}};
        div_r   <= op[1];
        neg_q_r <= sa_s ^ sb_s;
        opnd_r  <= op[1] ? mag(b, sb_s) : mag(a, sa_s);
        acc_r   <= {{WIDTH{1'b0}}, (op[1] ? mag(a, sa_s) : mag(b, sb_s))};
`ifdef MC_MULDIV_DIV_EN
        neg_r_r <= sa_s;
        dz_r    <= (b == {WIDTH{1'b0}});
        ovf_r   <= (op == 2'b11) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
        a_raw_r <= a;
`endif
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r + CW'(1);
        acc_r <= step_s;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Result registers load only on entry to DONE and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_lo_r <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      flags_r     <= 4'b0000;
      divzero_r   <= 1'b0;
    end else if (last_s) begin
      result_lo_r <= fin_lo_s;
      result_hi_r <= fin_hi_s;
      flags_r     <= fin_flags_s;
      divzero_r   <= fin_dz_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result_lo = result_lo_r;
  assign result_hi = result_hi_r;
  assign flags     = flags_r;
  assign divzero   = divzero_r;

endmodule

// File: tb/tb_mc_muldiv.sv
// Scoreboard bench for mc_muldiv (WIDTH=32): directed vectors push expectations, a monitor checks each done.
module tb_mc_muldiv;

  localparam int W = 32;
`ifdef MC_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, divzero;
  logic [W-1:0] result_lo, result_hi;
  logic [3:0]   flags;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  mc_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .flags(flags), .divzero(divzero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at a negedge; drives start for one cycle and records the expectation.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] lo, input logic [W-1:0] hi,
                       input logic [3:0] fl, input logic dz);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    e.lo = lo; e.hi = hi; e.fl = fl; e.dz = dz; e.due = cyc + W + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare every done pulse against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (busy) busy_cnt++;
      if (done) begin
        chk("busy_with_done", 64'(busy), 64'd0);
        chk("pending_op", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result_lo", 64'(result_lo), 64'(e.lo));
          chk("result_hi", 64'(result_hi), 64'(e.hi));
          chk("flags", 64'(flags), 64'(e.fl));
          chk("divzero", 64'(divzero), 64'(e.dz));
          chk("latency_cycle", 64'(cyc), 64'(e.due));
          chk("busy_cycles", 64'(busy_cnt), 64'(W));
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_divzero", 64'(divzero), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Multiply vectors
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 1'b0); drain();
    issue(2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1000, 1'b0); drain();
    issue(2'b01, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 4'b0100, 1'b0); drain();
    issue(2'b01, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFEC, 32'hFFFFFFFF, 4'b1000, 1'b0); drain();
    issue(2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 4'b0000, 1'b0); drain();

    // Divide vectors (all-zero results with Z when the divider is not built)
    issue(2'b10, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 32'd2 : 32'd0,
          DIV_EN ? 4'b0000 : 4'b0100, 1'b0); drain();
    issue(2'b11, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0,
          DIV_EN ? 4'b1000 : 4'b0100, 1'b0); drain();
    issue(2'b11, 32'd7, 32'hFFFFFFFE, DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 32'd1 : 32'd0,
          DIV_EN ? 4'b1000 : 4'b0100, 1'b0); drain();
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'h80000000 : 32'd0, 32'd0,
          DIV_EN ? 4'b1001 : 4'b0100, 1'b0); drain();
    issue(2'b11, 32'hFFFFFFF8, 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0, DIV_EN ? 32'hFFFFFFF8 : 32'd0,
          DIV_EN ? 4'b1000 : 4'b0100, DIV_EN); drain();

    // Start during RUN with other operands is ignored
    issue(2'b00, 32'd3, 32'd4, 32'd12, 32'd0, 4'b0000, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    // Back-to-back: second start issued during the DONE cycle
    issue(2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 4'b0000, 1'b0);
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    chk("b2b_first_done", 64'(done), 64'd1);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0000, 1'b0);
    drain();

    // Reset mid-RUN after a divide-by-zero left nonzero sticky results
    issue(2'b10, 32'd5, 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0, DIV_EN ? 32'd5 : 32'd0,
          DIV_EN ? 4'b1000 : 4'b0100, DIV_EN); drain();
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0, 4'b0000, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_lo", 64'(result_lo), 64'd0);
    chk("mid_rst_hi", 64'(result_hi), 64'd0);
    chk("mid_rst_flags", 64'(flags), 64'd0);
    chk("mid_rst_divzero", 64'(divzero), 64'd0);
    sb.delete();
    busy_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // Multiply still correct after reset
    issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 4'b0000, 1'b0); drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
